// File: rtl/pmpregfile.sv
// PMP configuration/address CSR register file: decodes pmpcfg*/pmpaddr* writes,
// applies lock and WARL rules, and exposes per-entry cfg/address to the checker.
module pmpregfile #(
   parameter int PMP_ENTRIES = 16,
   parameter int PA_BITS     = 56,
   parameter int XLEN        = 64
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                CSRWriteM,
   input  logic [11:0]                         CSRAdrM,
   input  logic [XLEN-1:0]                     CSRWriteValM,
   output logic [XLEN-1:0]                     CSRReadValM,
   output logic                                PMPHitM,
   output logic [PMP_ENTRIES*8-1:0]            PMPCFG_ARRAY_REGW,
   output logic [PMP_ENTRIES*(PA_BITS-2)-1:0]  PMPADDR_ARRAY_REGW,
   output logic                                PMPUpdateM
);
   localparam int AW  = PA_BITS - 2;
   localparam int BPC = XLEN / 8;
   localparam int NE  = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1;
   localparam int RW  = (XLEN > AW) ? XLEN : AW;

   logic            cfg_hit;
   logic            addr_hit;
   logic            write_en;
   logic [3:0]      cfg_grp;
   logic [5:0]      addr_idx;
   logic [AW-1:0]   addr_wdata;
   logic [NE-1:0]   cfg_chg;
   logic [NE-1:0]   addr_chg;
   logic [64*8-1:0] cfg_all;
   logic [64*AW-1:0] addr_all;
   logic [RW-1:0]   addr_rd;
   logic            update_next;
   logic            update_reg;
   logic            unused_wdata;

   // RV64 only implements even pmpcfg numbers; each covers eight entries.
   assign cfg_hit  = (CSRAdrM[11:4] == 8'h3A) && ((XLEN == 32) || !CSRAdrM[0]);
   assign addr_hit = (CSRAdrM >= 12'h3B0) && (CSRAdrM <= 12'h3EF);
   assign cfg_grp  = (XLEN == 64) ? {1'b0, CSRAdrM[3:1]} : CSRAdrM[3:0];
   assign addr_idx = CSRAdrM[5:0] - 6'h30;
   assign PMPHitM  = cfg_hit | addr_hit;
   assign write_en = CSRWriteM & PMPHitM;

   // Bits [6:5] of every cfg byte are never stored.
   assign unused_wdata = &{1'b0, CSRWriteValM};

   generate
      if (AW <= XLEN) begin : g_addr_narrow
         assign addr_wdata = CSRWriteValM[AW-1:0];
      end else begin : g_addr_wide
         assign addr_wdata = {{(AW-XLEN){1'b0}}, CSRWriteValM};
      end
   endgenerate

   generate
      if (PMP_ENTRIES > 0) begin : g_entries
         for (genvar gi = 0; gi < PMP_ENTRIES; gi++) begin : g_entry
            localparam logic [3:0] GRP = 4'(gi / BPC);
            localparam logic [5:0] IDX = 6'(gi);
            localparam int         B   = 8 * (gi % BPC);

            logic [7:0]    cfg_reg;
            logic [AW-1:0] addr_reg;
            logic [7:0]    cfg_new;
            logic          tor_lock;
            logic          cfg_we;
            logic          addr_we;

            // WARL: reserved bits cleared, W kept only when R is set.
            assign cfg_new = {CSRWriteValM[B+7], 2'b00, CSRWriteValM[B+4:B+3],
                              CSRWriteValM[B+2], CSRWriteValM[B+1] & CSRWriteValM[B],
                              CSRWriteValM[B]};

            // A locked TOR entry above also freezes this entry's address.
            if (gi + 1 < PMP_ENTRIES) begin : g_tor
               assign tor_lock = PMPCFG_ARRAY_REGW[8*(gi+1)+7] &&
                                 (PMPCFG_ARRAY_REGW[8*(gi+1)+4 -: 2] == 2'b01);
            end else begin : g_last
               assign tor_lock = 1'b0;
            end

            assign cfg_we  = write_en && cfg_hit && (cfg_grp == GRP) && !cfg_reg[7];
            assign addr_we = write_en && addr_hit && (addr_idx == IDX) &&
                             !cfg_reg[7] && !tor_lock;

            assign cfg_chg[gi]  = cfg_we && (cfg_new != cfg_reg);
            assign addr_chg[gi] = addr_we && (addr_wdata != addr_reg);

            always_ff @(posedge clk) begin
               if (!reset) begin
                  cfg_reg  <= '0;
                  addr_reg <= '0;
               end else begin
                  if (cfg_we) begin
                     cfg_reg <= cfg_new;
                  end
                  if (addr_we) begin
                     addr_reg <= addr_wdata;
                  end
               end
            end

            assign PMPCFG_ARRAY_REGW[8*gi +: 8]    = cfg_reg;
            assign PMPADDR_ARRAY_REGW[AW*gi +: AW] = addr_reg;
         end
      end else begin : g_no_entries
         assign cfg_chg  = '0;
         assign addr_chg = '0;
      end
   endgenerate

   // Full 64-entry view so unimplemented entries read as zero.
   generate
      for (genvar gi = 0; gi < 64; gi++) begin : g_pad
         if (gi < PMP_ENTRIES) begin : g_impl
            assign cfg_all[8*gi +: 8]    = PMPCFG_ARRAY_REGW[8*gi +: 8];
            assign addr_all[AW*gi +: AW] = PMPADDR_ARRAY_REGW[AW*gi +: AW];
         end else begin : g_zero
            assign cfg_all[8*gi +: 8]    = 8'h00;
            assign addr_all[AW*gi +: AW] = '0;
         end
      end
   endgenerate

   assign addr_rd = RW'(addr_all[AW*int'(addr_idx) +: AW]);

   always_comb begin
      CSRReadValM = '0;
      if (cfg_hit) begin
         CSRReadValM = cfg_all[XLEN*int'(cfg_grp) +: XLEN];
      end else if (addr_hit) begin
         CSRReadValM = addr_rd[XLEN-1:0];
      end
   end

   assign update_next = |{cfg_chg, addr_chg};

   always_ff @(posedge clk) begin
      if (!reset) begin
         update_reg <= 1'b0;
      end else begin
         update_reg <= update_next;
      end
   end

   assign PMPUpdateM = update_reg;

endmodule

// File: tb/tb_pmpregfile.sv
// Directed self-checking bench for pmpregfile (RV64, 16 entries, 56-bit PA).
module tb_pmpregfile;
   localparam int NE = 16;
   localparam int PA = 56;
   localparam int XL = 64;
   localparam int AW = PA - 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              CSRWriteM = 1'b0;
   logic [11:0]       CSRAdrM = '0;
   logic [XL-1:0]     CSRWriteValM = '0;
   logic [XL-1:0]     CSRReadValM;
   logic              PMPHitM;
   logic [NE*8-1:0]   PMPCFG_ARRAY_REGW;
   logic [NE*AW-1:0]  PMPADDR_ARRAY_REGW;
   logic              PMPUpdateM;

   int tests = 0;
   int fails = 0;

   pmpregfile #(.PMP_ENTRIES(NE), .PA_BITS(PA), .XLEN(XL)) dut (
      .clk                (clk),
      .reset              (reset),
      .CSRWriteM          (CSRWriteM),
      .CSRAdrM            (CSRAdrM),
      .CSRWriteValM       (CSRWriteValM),
      .CSRReadValM        (CSRReadValM),
      .PMPHitM            (PMPHitM),
      .PMPCFG_ARRAY_REGW  (PMPCFG_ARRAY_REGW),
      .PMPADDR_ARRAY_REGW (PMPADDR_ARRAY_REGW),
      .PMPUpdateM         (PMPUpdateM)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One-cycle write; returns at the negedge after the capturing edge.
   task automatic wr(input logic [11:0] a, input logic [63:0] v);
      @(negedge clk);
      CSRWriteM = 1'b1;
      CSRAdrM = a;
      CSRWriteValM = v;
      @(negedge clk);
      CSRWriteM = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
      CSRAdrM = a;
      #1;
      chk(tag, CSRReadValM, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "time limit");
   end

   initial begin
      // Reset
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      rd("rst_cfg0", 12'h3A0, 64'h0);
      rd("rst_addr5", 12'h3B5, 64'h0);
      chk("rst_hit", {63'h0, PMPHitM}, 64'h1);
      chk("rst_upd", {63'h0, PMPUpdateM}, 64'h0);
      chk("rst_cfgarr", {63'h0, |PMPCFG_ARRAY_REGW}, 64'h0);
      chk("rst_addrarr", {63'h0, |PMPADDR_ARRAY_REGW}, 64'h0);

      // cfg write, entry1 becomes locked NA4-free TOR with RWX
      wr(12'h3A0, 64'h8F03);
      chk("cfg_upd1", {63'h0, PMPUpdateM}, 64'h1);
      rd("cfg_rd1", 12'h3A0, 64'h8F03);
      chk("cfg_arr1", {48'h0, PMPCFG_ARRAY_REGW[15:0]}, 64'h8F03);
      @(negedge clk);
      chk("cfg_upd1_drop", {63'h0, PMPUpdateM}, 64'h0);
      wr(12'h3A0, 64'h0);
      chk("cfg_upd2", {63'h0, PMPUpdateM}, 64'h1);
      rd("cfg_rd2", 12'h3A0, 64'h8F00);

      // Reset clears lock; then entry1 locked TOR = 0x89
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      rd("rst2_cfg0", 12'h3A0, 64'h0);
      wr(12'h3A0, 64'h8900);
      rd("tor_cfg", 12'h3A0, 64'h8900);
      wr(12'h3B0, 64'h1234);
      chk("tor_upd0", {63'h0, PMPUpdateM}, 64'h0);
      rd("tor_addr0", 12'h3B0, 64'h0);
      wr(12'h3B1, 64'h5678);
      chk("tor_upd1", {63'h0, PMPUpdateM}, 64'h0);
      rd("tor_addr1", 12'h3B1, 64'h0);
      wr(12'h3B2, 64'h9ABC);
      chk("tor_upd2", {63'h0, PMPUpdateM}, 64'h1);
      rd("tor_addr2", 12'h3B2, 64'h9ABC);
      chk("tor_addrarr2", {10'h0, PMPADDR_ARRAY_REGW[2*AW +: AW]}, 64'h9ABC);

      // WARL: 0xE2 -> 0x80; byte2 still written while byte1 is locked
      wr(12'h3A0, 64'h0001_00E2);
      chk("warl_upd", {63'h0, PMPUpdateM}, 64'h1);
      rd("warl_rd", 12'h3A0, 64'h0001_8980);
      chk("warl_byte0", {56'h0, PMPCFG_ARRAY_REGW[7:0]}, 64'h80);

      // Unimplemented and invalid addresses
      wr(12'h3C4, 64'hFFFF);
      chk("pa20_upd", {63'h0, PMPUpdateM}, 64'h0);
      rd("pa20_rd", 12'h3C4, 64'h0);
      chk("pa20_hit", {63'h0, PMPHitM}, 64'h1);
      rd("cfg1_rd", 12'h3A1, 64'h0);
      chk("cfg1_hit", {63'h0, PMPHitM}, 64'h0);
      wr(12'h3A1, 64'hFF);
      chk("cfg1_upd", {63'h0, PMPUpdateM}, 64'h0);
      rd("non_pmp", 12'h300, 64'h0);
      chk("non_pmp_hit", {63'h0, PMPHitM}, 64'h0);
      rd("pa63_rd", 12'h3EF, 64'h0);
      chk("pa63_hit", {63'h0, PMPHitM}, 64'h1);
      rd("above_rd", 12'h3F0, 64'h0);
      chk("above_hit", {63'h0, PMPHitM}, 64'h0);

      // pmpcfg2 covers entries 8..15
      wr(12'h3A2, 64'h0B);
      rd("cfg2_rd", 12'h3A2, 64'h0B);
      chk("cfg2_arr8", {56'h0, PMPCFG_ARRAY_REGW[64 +: 8]}, 64'h0B);

      // All-ones address, then identical rewrite
      wr(12'h3B3, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("ones_upd", {63'h0, PMPUpdateM}, 64'h1);
      rd("ones_rd", 12'h3B3, 64'h003F_FFFF_FFFF_FFFF);
      wr(12'h3B3, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("same_upd", {63'h0, PMPUpdateM}, 64'h0);

      // Back-to-back changing writes keep the pulse high
      @(negedge clk);
      CSRWriteM = 1'b1;
      CSRAdrM = 12'h3B4;
      CSRWriteValM = 64'h1;
      @(negedge clk);
      chk("b2b_upd1", {63'h0, PMPUpdateM}, 64'h1);
      CSRAdrM = 12'h3B5;
      CSRWriteValM = 64'h2;
      @(negedge clk);
      CSRWriteM = 1'b0;
      chk("b2b_upd2", {63'h0, PMPUpdateM}, 64'h1);
      @(negedge clk);
      chk("b2b_drop", {63'h0, PMPUpdateM}, 64'h0);
      rd("b2b_addr5", 12'h3B5, 64'h2);

      // Reset overrides a same-cycle write and discards locks
      CSRWriteM = 1'b1;
      CSRAdrM = 12'h3B6;
      CSRWriteValM = 64'h55;
      reset = 1'b0;
      @(negedge clk);
      CSRWriteM = 1'b0;
      reset = 1'b1;
      chk("rstw_upd", {63'h0, PMPUpdateM}, 64'h0);
      rd("rstw_addr6", 12'h3B6, 64'h0);
      rd("rstw_cfg0", 12'h3A0, 64'h0);
      chk("rstw_addrarr", {63'h0, |PMPADDR_ARRAY_REGW}, 64'h0);
      wr(12'h3B1, 64'h77);
      chk("unlock_upd", {63'h0, PMPUpdateM}, 64'h1);
      rd("unlock_addr1", 12'h3B1, 64'h77);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
